// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: shares the two read ports and the write port of a
// register file between NREQ requesters. Round-robin grant, one transaction in
// flight, valid/ready handshakes on both the request and the response side.
module regfile_port_arbiter #(
  parameter int NREQ        = 2,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr_a,
  input  logic [NREQ*AW-1:0]   req_addr_b,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [DW-1:0]        resp_data_a,
  output logic [DW-1:0]        resp_data_b,
  output logic [AW-1:0]        rf_rd1_addr,
  output logic [AW-1:0]        rf_rd2_addr,
  input  logic [DW-1:0]        rf_rd1_data,
  input  logic [DW-1:0]        rf_rd2_data,
  output logic                 rf_wr_en,
  output logic [AW-1:0]        rf_wr_addr,
  output logic [DW-1:0]        rf_wr_data,
  output logic                 busy
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic            wr_q;
  logic [NREQ-1:0] resp_valid_q;
  logic [DW-1:0]   resp_data_a_q, resp_data_b_q;
  logic [AW-1:0]   rf_rd1_addr_q, rf_rd2_addr_q, rf_wr_addr_q;
  logic [DW-1:0]   rf_wr_data_q;
  logic            rf_wr_en_q;
  logic            busy_q;

  // Arbitration result and the winner's request fields
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     scan;
  logic            wr_d;
  logic [AW-1:0]   addr_a_d, addr_b_d;
  logic [DW-1:0]   wdata_d;
  logic [PW-1:0]   rr_ptr_d;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!win_found && req_valid[scan[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PW-1:0];
      end
    end
  end

  // Mux out the winner's request fields and the pointer after the current owner
  always_comb begin
    wr_d     = req_write[win_idx];
    addr_a_d = req_addr_a[win_idx*AW +: AW];
    addr_b_d = req_addr_b[win_idx*AW +: AW];
    wdata_d  = req_wdata[win_idx*DW +: DW];
    rr_ptr_d = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + PW'(1);
  end

  // Grant is the only combinational output; forced low while reset is asserted
  assign req_ready = (rst && (state_q == S_IDLE) && win_found)
                   ? (NREQ'(1) << win_idx) : '0;

  // Transaction FSM; every other output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      wr_q          <= 1'b0;
      resp_valid_q  <= '0;
      resp_data_a_q <= '0;
      resp_data_b_q <= '0;
      rf_rd1_addr_q <= '0;
      rf_rd2_addr_q <= '0;
      rf_wr_addr_q  <= '0;
      rf_wr_data_q  <= '0;
      rf_wr_en_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            // Load the port registers at accept so they are live during ACCESS
            owner_q       <= win_idx;
            wr_q          <= wr_d;
            rf_rd1_addr_q <= addr_a_d;
            rf_rd2_addr_q <= addr_b_d;
            if (wr_d) begin
              rf_wr_addr_q <= addr_a_d;
              rf_wr_data_q <= wdata_d;
              rf_wr_en_q   <= !(ZERO_REG_RO && (addr_a_d == '0));
            end
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Register file read is combinational; sample it at the end of ACCESS
          rf_wr_en_q    <= 1'b0;
          resp_data_a_q <= wr_q ? '0 : rf_rd1_data;
          resp_data_b_q <= wr_q ? '0 : rf_rd2_data;
          resp_valid_q  <= NREQ'(1) << owner_q;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's resp_ready can retire the transaction
          if (resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data_a = resp_data_a_q;
  assign resp_data_b = resp_data_b_q;
  assign rf_rd1_addr = rf_rd1_addr_q;
  assign rf_rd2_addr = rf_rd2_addr_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_addr  = rf_wr_addr_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a register-file model on the rf ports, a
// transaction-level reference model, directed scenarios and random traffic.
module tb_regfile_port_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [NREQ*AW-1:0]  req_addr_a, req_addr_b;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [DW-1:0]       resp_data_a, resp_data_b, rf_rd1_data, rf_rd2_data, rf_wr_data;
  logic [AW-1:0]       rf_rd1_addr, rf_rd2_addr, rf_wr_addr;
  logic                rf_wr_en, busy;

  regfile_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_REG_RO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data_a(resp_data_a), .resp_data_b(resp_data_b),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy)
  );

  // Power-up content of the register file (reg 0 reads as zero)
  function automatic logic [DW-1:0] initv(input logic [AW-1:0] a);
    if (a == '0) return '0;
    return 32'hA500_0000 ^ (32'(a) * 32'h0101_0101);
  endfunction

  // Register file: combinational reads, write on the clock edge
  logic [DW-1:0] rf_mem [32];
  logic          rf_w   [32] = '{default: 1'b0};
  always @(posedge clk) begin
    if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
      rf_w[rf_wr_addr]   <= 1'b1;
    end
  end
  assign rf_rd1_data = rf_w[rf_rd1_addr] ? rf_mem[rf_rd1_addr] : initv(rf_rd1_addr);
  assign rf_rd2_data = rf_w[rf_rd2_addr] ? rf_mem[rf_rd2_addr] : initv(rf_rd2_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 waiting, 1 register access, 2 response pending
  int            m_phase, m_owner, m_rr;
  logic          m_wr, m_wen;
  logic [AW-1:0] m_a, m_b, m_rd1, m_rd2, m_wa;
  logic [DW-1:0] m_wd, m_ra, m_rb;
  logic [DW-1:0] gold [32];
  int            grants [$];

  function automatic int winner();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_wr = 1'b0; m_wen = 1'b0;
    m_a = '0; m_b = '0; m_rd1 = '0; m_rd2 = '0; m_wa = '0;
    m_wd = '0; m_ra = '0; m_rb = '0;
  endtask

  task automatic model_step();
    int w;
    if (!rst) return;
    case (m_phase)
      0: begin
        w = winner();
        if (w >= 0) begin
          grants.push_back(w);
          m_owner = w;
          m_wr    = req_write[w];
          m_a     = req_addr_a[w*AW +: AW];
          m_b     = req_addr_b[w*AW +: AW];
          m_rd1   = m_a;
          m_rd2   = m_b;
          if (m_wr) begin
            m_wa  = m_a;
            m_wd  = req_wdata[w*DW +: DW];
            m_wen = (m_a != 0);
          end else m_wen = 1'b0;
          m_phase = 1;
        end
      end
      1: begin
        if (m_wr) begin
          if (m_wen) gold[m_wa] = m_wd;
          m_ra = '0; m_rb = '0;
        end else begin
          m_ra = gold[m_a]; m_rb = gold[m_b];
        end
        m_phase = 2;
      end
      default: begin
        if (resp_ready[m_owner]) begin
          m_phase = 0;
          m_rr    = (m_owner + 1) % NREQ;
        end
      end
    endcase
  endtask

  task automatic check_ready();
    int w;
    logic [NREQ-1:0] exp;
    w   = winner();
    exp = (rst && m_phase == 0 && w >= 0) ? NREQ'(1) << w : '0;
    chk("req_ready", req_ready, exp);
  endtask

  task automatic check_regs();
    chk("busy", busy, m_phase != 0);
    chk("rf_wr_en", rf_wr_en, (m_phase == 1) && m_wen);
    chk("resp_valid", resp_valid, (m_phase == 2) ? NREQ'(1) << m_owner : '0);
    chk("resp_data_a", resp_data_a, m_ra);
    chk("resp_data_b", resp_data_b, m_rb);
    chk("rf_rd1_addr", rf_rd1_addr, m_rd1);
    chk("rf_rd2_addr", rf_rd2_addr, m_rd2);
    chk("rf_wr_addr", rf_wr_addr, m_wa);
    chk("rf_wr_data", rf_wr_data, m_wd);
  endtask

  // One clock: check the grant for the inputs set by the caller, then the
  // registered outputs half a cycle after the edge
  task automatic cyc();
    #1 check_ready();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_addr_a = '0; req_addr_b = '0;
    req_wdata = '0; resp_ready = '1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr_a[i*AW +: AW] = a;
    req_addr_b[i*AW +: AW] = b;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic drain();
    int n;
    idle_inputs();
    n = 0;
    while (m_phase != 0 && n < 20) begin cyc(); n++; end
    chk("drain_timeout", m_phase, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gold[i] = initv(AW'(i));
    model_reset();
    rst = 1'b0;
    idle_inputs();
    req_valid = '1;

    // Reset state, with requests pending
    repeat (2) @(negedge clk);
    check_regs();
    #1 chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // Both requesters valid from reset: grants alternate starting at 0
    req_valid = '1;
    repeat (14) cyc();
    chk("rr_count", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      chk("rr_grant0", grants[0], 0);
      chk("rr_grant1", grants[1], 1);
      chk("rr_grant2", grants[2], 0);
      chk("rr_grant3", grants[3], 1);
    end
    drain();

    // Write reg1=16 then read reg1/reg2
    set_req(0, 1'b1, 5'd1, 5'd0, 32'd16);
    cyc();
    req_valid = '0;
    chk("t2_wen", rf_wr_en, 1);
    chk("t2_waddr", rf_wr_addr, 1);
    cyc();
    chk("t2_wen_one_cycle", rf_wr_en, 0);
    chk("t2_wack", resp_valid, 2'b01);
    chk("t2_wdata_zero", resp_data_a, 0);
    cyc();
    set_req(0, 1'b0, 5'd1, 5'd2, 32'd0);
    cyc();
    req_valid = '0;
    cyc();
    chk("t2_rd_a", resp_data_a, 32'd16);
    chk("t2_rd_b", resp_data_b, 32'hA702_0202);
    drain();

    // Write to reg 0 is suppressed but acknowledged
    set_req(1, 1'b1, 5'd0, 5'd0, 32'd22);
    cyc();
    req_valid = '0;
    chk("t4_wen0", rf_wr_en, 0);
    cyc();
    chk("t4_ack", resp_valid, 2'b10);
    drain();

    // Response stalled for 5 cycles with other requests waiting
    set_req(0, 1'b0, 5'd3, 5'd4, 32'd0);
    resp_ready = '0;
    cyc();
    set_req(1, 1'b0, 5'd5, 5'd6, 32'd0);
    cyc();
    repeat (5) begin
      cyc();
      chk("t5_ready", req_ready, 0);
      chk("t5_busy", busy, 1);
      chk("t5_valid", resp_valid, 2'b01);
    end
    drain();

    // Latency of a lone read: ACCESS after accept, response one cycle later
    set_req(1, 1'b0, 5'd5, 5'd6, 32'd0);
    cyc();
    req_valid = '0;
    chk("t6_rd1", rf_rd1_addr, 5);
    chk("t6_rd2", rf_rd2_addr, 6);
    chk("t6_no_resp", resp_valid, 0);
    cyc();
    chk("t6_resp", resp_valid, 2'b10);
    drain();

    // Asynchronous reset in the middle of a write's ACCESS cycle
    set_req(0, 1'b1, 5'd7, 5'd0, 32'hDEAD_BEEF);
    cyc();
    chk("t1_wen_before", rf_wr_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_wen", rf_wr_en, 0);
    chk("t1_busy", busy, 0);
    chk("t1_resp_valid", resp_valid, 0);
    chk("t1_rd1", rf_rd1_addr, 0);
    chk("t1_waddr", rf_wr_addr, 0);
    chk("t1_wdata", rf_wr_data, 0);
    chk("t1_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    cyc();

    // Random traffic over a small address window so reads hit earlier writes
    repeat (600) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]  = ($urandom_range(0, 2) != 0);
        req_write[i]  = ($urandom_range(0, 2) == 0);
        req_addr_a[i*AW +: AW] = AW'($urandom_range(0, 7));
        req_addr_b[i*AW +: AW] = AW'($urandom_range(0, 7));
        req_wdata[i*DW +: DW]  = $urandom;
        resp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
